// File: rtl/cache_1_controller.sv
// Direct-mapped L1 cache controller, write-through, no write-allocate.
// Owns the tag/valid store and drives the external data array and memory.
module cache_1_controller #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32,
  parameter int TWIDTH = 5,
  parameter int CWIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [TWIDTH+AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0]        cpu_wdata,
  output logic                     cpu_ready,
  output logic                     cpu_done,
  output logic [DWIDTH-1:0]        cpu_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [TWIDTH+AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DWIDTH-1:0]        mem_rdata,
  output logic [AWIDTH-1:0]        arr_addr,
  output logic [DWIDTH-1:0]        arr_data_in,
  output logic                     arr_write_enable,
  input  logic [DWIDTH-1:0]        arr_data_out,
  output logic [CWIDTH-1:0]        hit_count,
  output logic [CWIDTH-1:0]        miss_count
);

  localparam int LINES = 1 << AWIDTH;
  localparam int XW    = TWIDTH + AWIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    READ,
    MEM,
    UPDATE
  } state_t;

  state_t              state;
  logic [TWIDTH-1:0]   tag_mem [LINES];
  logic [LINES-1:0]    valid;
  logic [XW-1:0]       addr_q;
  logic                we_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [DWIDTH-1:0]   fill_q;
  logic                hit_q;

  logic [AWIDTH-1:0]   idx;
  logic [TWIDTH-1:0]   tag_q;
  logic                hit;

  assign idx   = addr_q[AWIDTH-1:0];
  assign tag_q = addr_q[XW-1:AWIDTH];
  assign hit   = valid[idx] && (tag_mem[idx] == tag_q);

  assign cpu_ready   = (state == IDLE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign arr_addr    = idx;
  assign arr_data_in = we_q ? wdata_q : fill_q;

  // Request sequencing, tag/valid store and statistics counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      valid            <= '0;
      for (int i = 0; i < LINES; i++)
        tag_mem[i]     <= '0;
      addr_q           <= '0;
      we_q             <= 1'b0;
      wdata_q          <= '0;
      fill_q           <= '0;
      hit_q            <= 1'b0;
      cpu_done         <= 1'b0;
      cpu_rdata        <= '0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      arr_write_enable <= 1'b0;
      hit_count        <= '0;
      miss_count       <= '0;
    end else begin
      cpu_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q <= hit;
          if (hit) begin
            if (hit_count != '1)
              hit_count <= hit_count + CWIDTH'(1);
          end else begin
            if (miss_count != '1)
              miss_count <= miss_count + CWIDTH'(1);
          end
          if (hit && !we_q) begin
            state <= READ;
          end else begin
            mem_req <= 1'b1;
            mem_we  <= we_q;
            state   <= MEM;
          end
        end
        READ: begin
          cpu_rdata <= arr_data_out;
          cpu_done  <= 1'b1;
          state     <= IDLE;
        end
        MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!we_q || hit_q) begin
              if (!we_q)
                fill_q <= mem_rdata;
              arr_write_enable <= 1'b1;
              state            <= UPDATE;
            end else begin
              cpu_done <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        UPDATE: begin
          arr_write_enable <= 1'b0;
          if (!we_q) begin
            tag_mem[idx] <= tag_q;
            valid[idx]   <= 1'b1;
            cpu_rdata    <= fill_q;
          end
          cpu_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_1_controller.sv
// Randomized bench for cache_1_controller against a
// behavioural cache/memory model; second instance checks saturation.
module tb_cache_1_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [2:0]  arr_addr;
  logic [31:0] arr_data_in;
  logic        arr_write_enable;
  logic [31:0] arr_data_out;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  logic        s_ready, s_done, s_mreq, s_mwe, s_awe;
  logic [31:0] s_rdata, s_mwdata, s_adin;
  logic [7:0]  s_maddr;
  logic [2:0]  s_aaddr;
  logic [1:0]  s_hit, s_miss;

  always #5 clock = ~clock;

  cache_1_controller dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .arr_addr(arr_addr), .arr_data_in(arr_data_in),
    .arr_write_enable(arr_write_enable),
    .arr_data_out(arr_data_out),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_1_controller #(.CWIDTH(2)) u_sat (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(s_ready), .cpu_done(s_done),
    .cpu_rdata(s_rdata),
    .mem_req(s_mreq), .mem_we(s_mwe),
    .mem_addr(s_maddr), .mem_wdata(s_mwdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .arr_addr(s_aaddr), .arr_data_in(s_adin),
    .arr_write_enable(s_awe),
    .arr_data_out(arr_data_out),
    .hit_count(s_hit), .miss_count(s_miss)
  );

  // Data array: one word per line, registered read.
  logic [31:0] arr_mem [8];
  always @(posedge clock) begin
    if (arr_write_enable)
      arr_mem[arr_addr] <= arr_data_in;
    arr_data_out <= arr_mem[arr_addr];
  end

  // Reference model: next-level memory plus tag/valid view.
  logic [31:0] backmem [256];
  logic        vld [8];
  logic [4:0]  tg [8];
  int          hits, misses;
  int          vectors, miscompares;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      vld[i] = 1'b0;
      tg[i]  = '0;
    end
    hits   = 0;
    misses = 0;
  endtask

  task automatic access(input logic we,
                        input logic [7:0] a,
                        input logic [31:0] wd,
                        input int d);
    logic [2:0] ix;
    logic [4:0] tv;
    logic       hit, seen;
    int         exp_c, c, mcnt, wcnt;
    ix  = a[2:0];
    tv  = a[7:3];
    hit = vld[ix] && (tg[ix] == tv);
    if (!we && hit)     exp_c = 3;
    else if (we && !hit) exp_c = 3 + d;
    else                 exp_c = 4 + d;
    mem_ack = 1'b0;
    check("ready_in", cpu_ready, 1);
    cpu_req = 1'b1; cpu_we = we;
    cpu_addr = a; cpu_wdata = wd;
    @(negedge clock);
    cpu_req = 1'b0;
    cpu_we = $urandom_range(0, 1);
    cpu_addr = $urandom; cpu_wdata = $urandom;
    c = 1; mcnt = 0; wcnt = 0; seen = 1'b0;
    while (c <= 30) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        mcnt++;
        if (mcnt == 1) begin
          check("mem_addr", mem_addr, a);
          check("mem_we", mem_we, we);
          if (we) check("mem_wdata", mem_wdata, wd);
        end
        if (mcnt == d + 1) begin
          mem_ack = 1'b1;
          mem_rdata = we ? $urandom : backmem[a];
        end
      end else if (c == 1 && $urandom_range(0, 1) == 1) begin
        mem_ack = 1'b1;
        mem_rdata = $urandom;
      end
      if (arr_write_enable) begin
        wcnt++;
        check("arr_addr", arr_addr, ix);
        check("arr_din", arr_data_in, we ? wd : backmem[a]);
      end
      if (cpu_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
      c++;
    end
    mem_ack = 1'b0;
    check("done_seen", seen, 1);
    check("latency", c, exp_c);
    check("mem_cycles", mcnt, (!we && hit) ? 0 : d + 1);
    check("arr_writes", wcnt, (we != hit) ? 0 : 1);
    if (hit) hits++; else misses++;
    if (we) begin
      backmem[a] = wd;
    end else begin
      if (!hit) begin
        vld[ix] = 1'b1;
        tg[ix]  = tv;
      end
      check("rdata", cpu_rdata, backmem[a]);
    end
    check("hit_count", hit_count, sat(hits, 65535));
    check("miss_count", miss_count, sat(misses, 65535));
    check("sat_hit", s_hit, sat(hits, 3));
    check("sat_miss", s_miss, sat(misses, 3));
    check("ready_done", cpu_ready, 1);
  endtask

  task automatic reset_in_mem(input logic [7:0] a);
    int n;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(negedge clock);
    cpu_req = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("rst_mreq_pre", mem_req, 1);
    #1 reset = 1'b1;
    #1 check("rst_mreq_drop", mem_req, 0);
    check("rst_ready", cpu_ready, 1);
    cpu_req = 1'b1;
    @(negedge clock);
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    @(negedge clock);
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    reset = 1'b0;
    model_reset();
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    check("rst_no_mreq", mem_req, 0);
    check("rst_no_done", cpu_done, 0);
    check("rst_ready2", cpu_ready, 1);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_hits", hit_count, 0);
    check("rst_miss", miss_count, 0);
    @(negedge clock);
    check("rst_no_done2", cpu_done, 0);
  endtask

  task automatic idle_gap();
    int k;
    k = $urandom_range(0, 2);
    for (int i = 0; i < k; i++) begin
      mem_ack = $urandom_range(0, 1);
      mem_rdata = $urandom;
      @(negedge clock);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 8; i++) arr_mem[i] = '0;
    for (int i = 0; i < 256; i++) backmem[i] = $urandom;
    backmem[8'h15] = 32'hDEADBEEF;
    model_reset();
    repeat (2) @(negedge clock);
    cpu_req = 1'b1;
    @(negedge clock);
    check("r_ready", cpu_ready, 1);
    check("r_done", cpu_done, 0);
    check("r_rdata", cpu_rdata, 0);
    check("r_hits", hit_count, 0);
    check("r_miss", miss_count, 0);
    check("r_mreq", mem_req, 0);
    check("r_mwe", mem_we, 0);
    check("r_awe", arr_write_enable, 0);
    cpu_req = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("r_not_taken", cpu_ready, 1);

    access(1'b0, 8'h15, '0, 3);
    access(1'b0, 8'h15, '0, 0);
    access(1'b0, 8'h1D, '0, 1);
    access(1'b0, 8'h15, '0, 2);
    check("miss3", miss_count, 3);
    access(1'b0, 8'h1D, '0, 0);
    access(1'b1, 8'h1D, 32'h12345678, 1);
    access(1'b0, 8'h1D, '0, 0);
    check("wr_hit_data", cpu_rdata, 32'h12345678);
    access(1'b1, 8'h40, 32'hCAFEF00D, 0);
    access(1'b0, 8'h40, '0, 2);
    reset_in_mem(8'h15);
    access(1'b0, 8'h15, '0, 1);
    for (int i = 0; i < 5; i++) access(1'b0, 8'h15, '0, 0);
    check("sat_final", s_hit, 3);

    for (int i = 0; i < 200; i++) begin
      logic [7:0] a;
      a = {3'b000, 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7))};
      idle_gap();
      access($urandom_range(0, 9) < 3, a,
             $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_1_controller.md
# cache_1_controller

Direct-mapped L1 cache controller sitting directly upstream of the level-1 data array. It accepts one CPU request at a time, keeps the tag and valid store, and drives the array's address, write-data and write-enable ports. On a miss it fetches the word from next-level memory over a req/ack handshake. Writes are write-through to memory; writes that miss do not allocate a line.

## Interface
- AWIDTH, 3, index width; must match the data array's address width (2^AWIDTH lines, one word per line)
- DWIDTH, 32, data word width; must match the data array
- TWIDTH, 5, tag width; CPU/memory address width is TWIDTH+AWIDTH
- CWIDTH, 16, width of the hit/miss statistics counters
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  request strobe; sampled only while cpu_ready=1
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  TWIDTH+AWIDTH  {tag, index}
- cpu_wdata  in  DWIDTH  write data
- cpu_ready  out  1  controller is idle and can accept a request
- cpu_done  out  1  one-cycle completion pulse (registered)
- cpu_rdata  out  DWIDTH  read result; valid while cpu_done=1 for reads (registered)
- mem_req  out  1  next-level request; held until mem_ack
- mem_we  out  1  next-level write
- mem_addr  out  TWIDTH+AWIDTH  next-level address
- mem_wdata  out  DWIDTH  next-level write data
- mem_ack  in  1  one-cycle completion from next level; mem_rdata valid with it
- mem_rdata  in  DWIDTH  next-level read data
- arr_addr  out  AWIDTH  data array address
- arr_data_in  out  DWIDTH  data array write data
- arr_write_enable  out  1  data array write strobe
- arr_data_out  in  DWIDTH  data array read data; one cycle after arr_addr is sampled
- hit_count  out  CWIDTH  saturating hit counter
- miss_count  out  CWIDTH  saturating miss counter

## Operation
- Internal state: tag store (2^AWIDTH x TWIDTH), valid bits, request latches (addr_q, we_q, wdata_q), hit_q, fill_q.
- FSM states: IDLE, LOOKUP, READ, MEM, UPDATE.
- IDLE: cpu_ready=1. With cpu_req=1 and reset low, latch the request and go to LOOKUP.
- LOOKUP: hit = valid[idx] and (tag[idx]==tag_q). Register the result into hit_q and bump one counter.
  - Read hit: go to READ.
  - Any other case: go to MEM.
- READ: arr_data_out is valid. Load cpu_rdata<=arr_data_out, pulse cpu_done, go to IDLE.
- MEM: mem_req=1, mem_addr=addr_q, mem_we=we_q, mem_wdata=wdata_q. mem_ack is ignored in every other state. On mem_ack:
  - Read, or write with hit_q=1: fill_q<=mem_rdata (reads only), go to UPDATE.
  - Write with hit_q=0: pulse cpu_done, go to IDLE.
- UPDATE: arr_write_enable=1, arr_data_in = fill_q (read) or wdata_q (write).
  - For reads, also set tag[idx]<=tag_q, valid[idx]<=1, and cpu_rdata<=fill_q.
  - Pulse cpu_done, go to IDLE.
- arr_addr = index of addr_q at all times. arr_write_enable is 0 outside UPDATE.
- Counters increment by exactly 1 per access at the LOOKUP exit edge, reads and writes both, and saturate at all-ones.
- Reset (asynchronous): state IDLE; all valid bits 0; tag store 0; cpu_done=0; cpu_rdata=0; fill_q=0; counters 0; mem_req/mem_we/arr_write_enable=0.
  - cpu_ready=1 during reset, but no request is accepted while reset is high.
  - Reset during MEM drops mem_req immediately. A later mem_ack is ignored.

## Timing
- Accept edge = E0.
- Read hit: LOOKUP in cycle 1, READ in cycle 2, cpu_done high in cycle 3.
- Read miss: mem_req high from cycle 2 until the ack edge. UPDATE runs the cycle after the ack. cpu_done comes the cycle after UPDATE.
- Write hit: same as read miss, with the array write in UPDATE.
- Write miss: cpu_done in the cycle after the ack edge.
- cpu_ready is high in the same cycle as cpu_done, so back-to-back requests are allowed. A request accepted then observes the just-updated tag and valid bits.
- mem_ack in the same cycle mem_req first rises is legal and completes the MEM state.

## Test plan
- Reset, read 0x15 (tag 2, idx 5), ack mem_rdata=0xDEADBEEF 3 cycles later:
  - mem_addr=0x15, mem_we=0; array write at idx 5 in UPDATE.
  - cpu_rdata=0xDEADBEEF with cpu_done; miss_count=1.
- Re-read 0x15: no mem_req; cpu_done 3 cycles after accept; cpu_rdata=0xDEADBEEF; hit_count=1.
- Read 0x1D (tag 3, idx 5), then 0x15: both miss, because the second replaces the first. miss_count=3.
- Write 0x1D with 0x12345678 after that line is filled:
  - mem_we=1, mem_wdata=0x12345678; arr_write_enable one cycle after the ack.
  - A subsequent read of 0x1D hits with 0x12345678.
- Write 0x40 on a cold line: a memory write only, with arr_write_enable never high. A following read of 0x40 misses.
- Assert reset while in MEM, then pulse mem_ack: mem_req falls immediately, cpu_done stays 0, and a read of 0x15 afterwards misses.
- With CWIDTH=2, five hits to 0x15: hit_count saturates at 3.
